alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: N, default 4, operand/result width in bits; SHALL match the N of the attached ALU.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0, req1  input  1 each  requester k asks for one ALU operation; level, held until done_k.
REQ-005 op0, op1  input  5 each  opcode of requester k; stable while req_k high.
REQ-006 a0, b0, a1, b1  input  N each  operands of requester k; stable while req_k high.
REQ-007 done0, done1  output  1 each  one-cycle pulse: requester k's operation complete, result valid.
REQ-008 result  output  N  last completed ALU result; held until the next completion.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 grant  output  1  index of the requester currently or last served.
REQ-011 alu_start  output  1  one-cycle start pulse to ALU start.
REQ-012 alu_opcode  output  5; alu_a, alu_b  output  N  registered copies of granted requester's opcode/operands.
REQ-013 alu_finished  input  1; alu_y  input  N  from ALU finished and Y.

Function
REQ-014 FSM states: IDLE, START, WAIT, DONE; one state per cycle except WAIT.
REQ-015 IDLE: if no req, stay; if exactly one req_k, grant k; if both, grant the requester not served last (round-robin); go START.
REQ-016 On leaving IDLE, op_k/a_k/b_k of granted k SHALL be registered into alu_opcode/alu_a/alu_b; these hold until the next grant.
REQ-017 START: alu_start=1 for exactly this cycle; go WAIT.
REQ-018 WAIT: alu_start=0; on first cycle alu_finished=1, register alu_y into result, go DONE; otherwise stay (no timeout).
REQ-019 DONE: done_grant=1, other done=0; update last-served pointer to grant; go IDLE.
REQ-020 Latency: req sampled in IDLE at cycle 0 -> alu_start in cycle 1 -> ALU finished in cycle 1+k (k>=1) -> done and new result in cycle 2+k.
REQ-021 Requester SHALL drop req_k at the edge after seeing done_k unless requesting again; a held req_k is served again but always yields to a waiting other requester.
REQ-022 req_k deasserted after grant: operation still completes and done_k still pulses.
REQ-023 Operand/opcode changes on the ungranted port or after grant SHALL NOT affect the operation in flight.
REQ-024 alu_finished outside WAIT SHALL be ignored.
REQ-025 done0 and done1 SHALL never be high in the same cycle; at most one alu_start per operation.

Reset
REQ-026 Reset asserted (any state, including WAIT mid-operation): state=IDLE, alu_start=0, done0=done1=0, busy=0, grant=0, result=0, alu_opcode/alu_a/alu_b=0, last-served pointer=1 (requester 0 wins first tie).
REQ-027 In-flight operation SHALL be abandoned without done; ALU shares the same reset.
REQ-028 First grant possible in first IDLE cycle after reset deasserts.

Structure
REQ-029 Shared package alu_arbiter_pkg: state enum (IDLE, START, WAIT, DONE), OPCODE_WIDTH=5.
REQ-030 One sub-module rr_select: 2-request round-robin picker (inputs req0, req1, last; outputs valid, pick), combinational.
REQ-031 Top instantiates rr_select; ALU instantiated in the testbench next to the arbiter, not inside it.

Verification
Bench ALU stub: finished 3 cycles after start, Y = A+B mod 2^N, N=4.
REQ-032 req0=1, a0=3, b0=4 in IDLE at cycle 0 -> alu_start cycle 1, done0 cycle 5, result=7, busy cycles 1-5.
REQ-033 req0 and req1 rise together after reset (a0=1,b0=1; a1=2,b1=5) -> requester 0 first (result=2, done0), then requester 1 (result=7, done1); no overlap.
REQ-034 Both req held high for 4 operations -> grant alternates 0,1,0,1; done pulses alternate.
REQ-035 Reset asserted during WAIT of requester 1 -> all outputs at reset values within same cycle, no done1; after release req0 served normally.
REQ-036 req1 granted with a1=15,b1=2, then a1/b1 changed to 0 during WAIT -> result=1 (wrap), done1 once.
REQ-037 Spurious alu_finished=1 pulse in IDLE -> no state change, no done, result unchanged.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: definitions shared by the arbiter sources.
//   OPCODE_WIDTH : width of the requester and ALU opcode fields
//   state_t      : arbiter FSM state encoding (IDLE, START, WAIT, DONE)
package alu_arbiter_pkg;

    localparam int unsigned OPCODE_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_select.sv
// rr_select: combinational two-requester round-robin picker.
//   req0, req1 : request levels
//   last       : index of the requester served most recently
//   valid      : at least one request is present
//   pick       : index of the requester to serve next
module rr_select (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic pick
);

    assign valid = req0 | req1;

    // On a tie the requester that was not served last wins.
    assign pick = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external multi-cycle ALU between two requesters.
//   clock, reset                      : clock, asynchronous active-high reset
//   req0/1, op0/1, a0/1, b0/1         : requester level request, opcode, operands
//   done0/1                           : one-cycle completion pulse per requester
//   result                            : last completed ALU result
//   busy, grant                       : FSM not idle, index of requester served
//   alu_start, alu_opcode, alu_a/b    : registered command to the ALU
//   alu_finished, alu_y               : ALU completion and result
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    req1,
    input  logic [OPCODE_WIDTH-1:0] op0,
    input  logic [OPCODE_WIDTH-1:0] op1,
    input  logic [N-1:0]            a0,
    input  logic [N-1:0]            b0,
    input  logic [N-1:0]            a1,
    input  logic [N-1:0]            b1,
    output logic                    done0,
    output logic                    done1,
    output logic [N-1:0]            result,
    output logic                    busy,
    output logic                    grant,
    output logic                    alu_start,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    output logic [N-1:0]            alu_a,
    output logic [N-1:0]            alu_b,
    input  logic                    alu_finished,
    input  logic [N-1:0]            alu_y
);

    state_t state;
    state_t state_nxt;
    logic   last;
    logic   sel_valid;
    logic   sel_pick;

    rr_select u_rr_select (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .valid (sel_valid),
        .pick  (sel_pick)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; alu_finished only matters while waiting.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_valid) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (alu_finished) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status and pulse outputs, registered from the next state so they line up with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            alu_start <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
        end else begin
            busy      <= (state_nxt != IDLE);
            alu_start <= (state_nxt == START);
            done0     <= (state_nxt == DONE) && (grant == 1'b0);
            done1     <= (state_nxt == DONE) && (grant == 1'b1);
        end
    end

    // Grant and ALU command capture; held until the next grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant      <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else if ((state == IDLE) && sel_valid) begin
            grant      <= sel_pick;
            alu_opcode <= sel_pick ? op1 : op0;
            alu_a      <= sel_pick ? a1  : a0;
            alu_b      <= sel_pick ? b1  : b0;
        end
    end

    // Result capture on ALU completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result <= '0;
        end else if ((state == WAIT) && alu_finished) begin
            result <= alu_y;
        end
    end

    // Last-served pointer; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (state == DONE) begin
            last <= grant;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: bench for alu_arbiter with an adder ALU stub
// (finished three cycles after start, Y = A + B mod 16).
module tb_alu_arbiter;

    localparam int unsigned N = 4;

    logic       clock;
    logic       reset;
    logic       req0, req1;
    logic [4:0] op0, op1;
    logic [3:0] a0, b0, a1, b1;
    logic       done0, done1;
    logic [3:0] result;
    logic       busy, grant, alu_start;
    logic [4:0] alu_opcode;
    logic [3:0] alu_a, alu_b;
    logic       alu_finished;
    logic [3:0] alu_y;

    logic [2:0] stub_cnt;
    logic [3:0] stub_y;
    logic       spur;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int last_served = 1;
    int ref_result  = 0;

    alu_arbiter #(.N(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .op0          (op0),
        .op1          (op1),
        .a0           (a0),
        .b0           (b0),
        .a1           (a1),
        .b1           (b1),
        .done0        (done0),
        .done1        (done1),
        .result       (result),
        .busy         (busy),
        .grant        (grant),
        .alu_start    (alu_start),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_finished (alu_finished),
        .alu_y        (alu_y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ALU stub
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stub_cnt <= 3'd0;
            stub_y   <= 4'd0;
        end else if (alu_start) begin
            stub_cnt <= 3'd3;
            stub_y   <= 4'(alu_a + alu_b);
        end else if (stub_cnt != 3'd0) begin
            stub_cnt <= stub_cnt - 3'd1;
        end
    end
    assign alu_finished = (stub_cnt == 3'd1) | spur;
    assign alu_y        = stub_y;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction: starts at the negedge of an IDLE cycle, ends at the negedge of DONE.
    // mode: 0 keep operands, 1 zero all operands during WAIT, 2 randomize them during WAIT.
    task automatic do_txn(input bit r0, input bit r1, input int mode, input bit hold);
        int         k;
        logic [4:0] eop;
        logic [3:0] ea, eb, ey;
        @(negedge clock);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'({done1, done0}), 32'd0);
        req0 = r0;
        req1 = r1;
        // Model: lone requester wins; on a tie the one not served last wins.
        if (r0 && r1) k = (last_served == 0) ? 1 : 0;
        else          k = r1 ? 1 : 0;
        eop = (k == 1) ? op1 : op0;
        ea  = (k == 1) ? a1  : a0;
        eb  = (k == 1) ? b1  : b0;
        ey  = 4'((int'(ea) + int'(eb)) % 16);
        @(negedge clock);
        chk("start_pulse", 32'(alu_start), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("grant", 32'(grant), 32'(k));
        chk("alu_opcode", 32'(alu_opcode), 32'(eop));
        chk("alu_a", 32'(alu_a), 32'(ea));
        chk("alu_b", 32'(alu_b), 32'(eb));
        chk("start_done", 32'({done1, done0}), 32'd0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clock);
            chk("wait_start", 32'(alu_start), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_done", 32'({done1, done0}), 32'd0);
            chk("wait_result_held", 32'(result), 32'(ref_result));
            chk("wait_alu_a_held", 32'(alu_a), 32'(ea));
            if (c == 2 && mode == 1) begin
                a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
            end else if (c == 2 && mode == 2) begin
                a0 = 4'($urandom); b0 = 4'($urandom);
                a1 = 4'($urandom); b1 = 4'($urandom);
                op0 = 5'($urandom); op1 = 5'($urandom);
            end
        end
        @(negedge clock);
        chk("done_pulse", 32'({done1, done0}), (k == 1) ? 32'd2 : 32'd1);
        chk("done_result", 32'(result), 32'(ey));
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_start", 32'(alu_start), 32'd0);
        if (!hold) begin
            if (k == 1) req1 = 1'b0;
            else        req0 = 1'b0;
        end
        last_served = k;
        ref_result  = int'(ey);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 5'd0; op1 = 5'd0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        spur = 1'b0;

        // Reset values
        @(negedge clock);
        @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'({done1, done0}), 32'd0);
        chk("rst_start", 32'(alu_start), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cmd", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        reset = 1'b0;

        // Simultaneous requests after reset: requester 0 first, then 1
        a0 = 4'd1; b0 = 4'd1; op0 = 5'd3;
        a1 = 4'd2; b1 = 4'd5; op1 = 5'd17;
        do_txn(1'b1, 1'b1, 0, 1'b0);
        do_txn(1'b0, 1'b1, 0, 1'b0);

        // Both held for four operations: grant alternates
        for (int i = 0; i < 4; i++) begin
            a0 = 4'($urandom); b0 = 4'($urandom); op0 = 5'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom); op1 = 5'($urandom);
            do_txn(1'b1, 1'b1, 0, 1'b1);
        end

        // Single requester 0: 3 + 4
        a0 = 4'd3; b0 = 4'd4; op0 = 5'd1;
        do_txn(1'b1, 1'b0, 0, 1'b0);
        chk("single_result", 32'(result), 32'd7);

        // Requester 1 with wrap, operands zeroed during WAIT
        a1 = 4'd15; b1 = 4'd2; op1 = 5'd2;
        do_txn(1'b0, 1'b1, 1, 1'b0);
        chk("wrap_result", 32'(result), 32'd1);

        // Spurious alu_finished in IDLE
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clock);
        spur = 1'b1;
        @(negedge clock);
        spur = 1'b0;
        chk("spur_busy", 32'(busy), 32'd0);
        chk("spur_done", 32'({done1, done0}), 32'd0);
        chk("spur_result", 32'(result), 32'(ref_result));
        @(negedge clock);
        chk("spur_busy2", 32'(busy), 32'd0);
        chk("spur_done2", 32'({done1, done0}), 32'd0);

        // Reset while requester 1 waits on the ALU
        a1 = 4'd9; b1 = 4'd9; op1 = 5'd9;
        req1 = 1'b1;
        @(negedge clock);
        chk("mid_grant", 32'(grant), 32'd1);
        chk("mid_start", 32'(alu_start), 32'd1);
        @(negedge clock);
        @(negedge clock);
        chk("mid_wait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        req1  = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'({done1, done0}), 32'd0);
        chk("mid_rst_start", 32'(alu_start), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_cmd", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        @(negedge clock);
        chk("mid_rst_no_done1", 32'(done1), 32'd0);
        reset = 1'b0;
        last_served = 1;
        ref_result  = 0;
        @(negedge clock);
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_no_done", 32'({done1, done0}), 32'd0);

        // After reset: tie goes to requester 0 again, then 1
        a0 = 4'd6; b0 = 4'd7; op0 = 5'd4;
        a1 = 4'd8; b1 = 4'd8; op1 = 5'd5;
        do_txn(1'b1, 1'b1, 0, 1'b0);
        do_txn(1'b0, 1'b1, 0, 1'b0);

        // Randomized transactions
        for (int i = 0; i < 24; i++) begin
            bit r0, r1;
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) begin
                if ($urandom_range(0, 1) == 1) r1 = 1'b1;
                else                           r0 = 1'b1;
            end
            a0 = 4'($urandom); b0 = 4'($urandom); op0 = 5'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom); op1 = 5'($urandom);
            do_txn(r0, r1, int'($urandom_range(0, 2)), 1'($urandom));
        end

        req0 = 1'b0; req1 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("final_idle", 32'(busy), 32'd0);
        chk("final_result", 32'(result), 32'(ref_result));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
